// File: rtl/y86_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | y86_pkg : shared Y86-64 status codes, register ids and icodes     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package y86_pkg;

    localparam logic [2:0] STAT_BUB = 3'd0;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Codes above INS have no architectural meaning and report as INS.
    function automatic logic [2:0] stat_norm(input logic [2:0] s);
        return (s > STAT_INS) ? STAT_INS : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/y86_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | y86_regfile : NREGS x 64 register file, 2 write / 2 read ports   |
// | Optional same-cycle write-through when WB_BYPASS_EN is defined.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module y86_regfile
    import y86_pkg::*;
#(
    parameter int NREGS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rval_a,
    output logic [63:0] rval_b
);

    logic [63:0] r_regs [NREGS];

    // M is written last so it overrides E on a shared destination (popq %rsp).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (we_e && (int'(dst_e) < NREGS)) begin
                r_regs[dst_e] <= val_e;
            end
            if (we_m && (int'(dst_m) < NREGS)) begin
                r_regs[dst_m] <= val_m;
            end
        end
    end

    function automatic logic [63:0] rd_port(input logic [3:0] addr);
        logic [63:0] v;
        v = '0;
        if ((addr != RNONE) && (int'(addr) < NREGS)) begin
            v = r_regs[addr];
        end
`ifdef WB_BYPASS_EN
        if (we_e && (dst_e == addr)) begin
            v = val_e;
        end
        if (we_m && (dst_m == addr)) begin
            v = val_m;
        end
`endif
        return v;
    endfunction

    always_comb begin
        rval_a = rd_port(src_a);
        rval_b = rd_port(src_b);
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_stage : Y86-64 PIPE writeback - commit, status FSM, retire cnt |
// | Option macro: WB_BYPASS_EN (read write-through in y86_regfile).   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module wb_stage
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       w_stat,
    input  logic [3:0]       w_icode,
    input  logic [63:0]      w_valE,
    input  logic [63:0]      w_valM,
    input  logic [3:0]       w_dstE,
    input  logic [3:0]       w_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [2:0]       cpu_stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_STOP = 1'b1
    } state_t;

    state_t r_state;

    logic w_run;
    logic w_fault;
    logic w_commit_e;
    logic w_commit_m;
    logic w_retire;

    // icode only feeds external trace hooks; keep it referenced.
    logic w_unused_icode;
    assign w_unused_icode = &{1'b0, w_icode};

    assign w_run      = (r_state == S_RUN);
    assign w_fault    = (w_stat != STAT_BUB) && (w_stat != STAT_AOK);
    assign w_commit_e = w_run && (w_stat == STAT_AOK) && (w_dstE != RNONE);
    assign w_commit_m = w_run && (w_stat == STAT_AOK) && (w_dstM != RNONE);
    assign w_retire   = w_run && ((w_stat == STAT_AOK) || (w_stat == STAT_HLT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            cpu_stat <= STAT_AOK;
            halted   <= 1'b0;
            retired  <= '0;
        end else begin
            if (w_retire) begin
                retired <= retired + CNT_W'(1);
            end
            case (r_state)
                S_RUN: begin
                    if (w_fault) begin
                        r_state  <= S_STOP;
                        halted   <= 1'b1;
                        cpu_stat <= stat_norm(w_stat);
                    end else begin
                        cpu_stat <= STAT_AOK;
                    end
                end
                S_STOP: begin
                    halted <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    y86_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_e   (w_commit_e),
        .dst_e  (w_dstE),
        .val_e  (w_valE),
        .we_m   (w_commit_m),
        .dst_m  (w_dstM),
        .val_m  (w_valM),
        .src_a  (d_srcA),
        .src_b  (d_srcB),
        .rval_a (d_rvalA),
        .rval_b (d_rvalB)
    );

endmodule
`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the PIPE Y86-64 processor. It consumes the W pipeline register outputs (`w_stat`, `w_icode`, `w_valE`, `w_valM`, `w_dstE`, `w_dstM`) and commits results into the 15-entry program register file. It serves the decode stage's two read ports (`srcA`, `srcB`) and holds the processor status state machine that stops the machine on halt or exception. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `NREGS`, 15: number of architectural registers, indices 0..14; index 0xF is `RNONE`.
- `CNT_W`, 64: width of the retired-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `w_stat`  in  3  status of the instruction in W.
- `w_icode`  in  4  icode of the instruction in W.
- `w_valE`  in  64  ALU result.
- `w_valM`  in  64  memory result.
- `w_dstE`  in  4  destination for `valE`; 0xF means none.
- `w_dstM`  in  4  destination for `valM`; 0xF means none.
- `d_srcA`  in  4  decode read address A.
- `d_srcB`  in  4  decode read address B.
- `d_rvalA`  out  64  register value at `d_srcA`; 0 when the address is 0xF.
- `d_rvalB`  out  64  register value at `d_srcB`; 0 when the address is 0xF.
- `cpu_stat`  out  3  architectural status.
- `halted`  out  1  high once the machine has stopped.
- `retired`  out  `CNT_W`  count of committed instructions.

## Operation
Status codes (3 bits):
- BUB=0, AOK=1, HLT=2, ADR=3, INS=4.
- Codes 5–7 are illegal and are treated as INS.

Status FSM:
- States: RUN, STOP. Reset state is RUN.
- RUN → STOP when `w_stat` ∉ {BUB, AOK}.
- STOP is sticky until reset.
- `halted` = (state == STOP).
- On the RUN→STOP edge, `cpu_stat` latches `w_stat`, with illegal codes mapped to INS.
- In RUN, `cpu_stat` = AOK.

Commit rule. A write is enabled only when all of the following hold:
- state == RUN;
- `w_stat` == AOK;
- dst != 0xF.

Commit behaviour:
- Port E writes `w_valE` to `w_dstE`; port M writes `w_valM` to `w_dstM`.
- Both ports may write in the same cycle.
- If `w_dstE` == `w_dstM`, port M wins. This covers `popq %rsp`, where `%rsp` receives `valM`.
- The instruction that causes the halt (HLT/ADR/INS) writes nothing.

Reads:
- Combinational from the register array.
- Address 0xF returns 0.

Counter:
- `retired` increments by 1 each cycle in which state == RUN and `w_stat` ∈ {AOK, HLT}.
- The HLT instruction is counted. ADR, INS and BUB are not.
- Wraps modulo 2^`CNT_W`.

`w_icode` is not used for commit decisions. It exists for the trace hooks.

## Timing
- Write latency: a write is visible in the array, and therefore on a read, the cycle after the edge that commits it.
- Forwarding: without the bypass option, same-cycle forwarding is the job of the decode forwarding logic.
- `halted` and `cpu_stat` update at the edge where the faulting instruction sits in W.
- `retired` updates at the same edge.

Reset (`rst_n` low at the rising edge) takes priority over every write and over the FSM:
- all registers := 0;
- state := RUN;
- `cpu_stat` := AOK;
- `halted` := 0;
- `retired` := 0.

Reset in STOP returns the block to RUN.

Simultaneous events:
- A write and a read to the same address in one cycle return the old value, unless the bypass option is compiled in.
- A halt in the same cycle as an AOK write cannot happen, because W holds only one instruction.

## Configuration
- `WB_BYPASS_EN` defined: read ports return same-cycle write data when the read address matches an enabled write.
  - M has priority over E, matching the commit rule.
  - Reads become write-through.
- `WB_BYPASS_EN` not defined: reads return array contents only.

## Structure
Shared package `y86_pkg` holds:
- stat codes STAT_BUB/AOK/HLT/ADR/INS;
- `RNONE` = 4'hF and `RRSP` = 4'h4;
- icode constants.

Sub-module `y86_regfile` contains:
- the `NREGS`×64 array;
- two write ports with M-over-E priority;
- two combinational read ports;
- the `WB_BYPASS_EN` path.

`wb_stage` instantiates `y86_regfile`. It contains the FSM, the commit enables and the counter.

## Test plan
- Reset, then read all 15 registers → every `d_rval` = 0; `cpu_stat`=AOK; `halted`=0; `retired`=0.
- Input AOK, dstE=2 (valE=0x1234), dstM=3 (valM=0xBEEF) → next cycle reg2=0x1234, reg3=0xBEEF; `retired`=1.
- Input AOK, dstE=dstM=4, valE=0x100, valM=0x200 → reg4=0x200.
- Input HLT with dstE=1, valE=5 → reg1 unchanged, `halted`=1, `cpu_stat`=2, `retired` incremented. Following AOK writes are ignored and `retired` stays frozen.
- Input ADR → `cpu_stat`=3 and `retired` not incremented. Input `w_stat`=6 instead → `cpu_stat`=4. Then hold `rst_n`=0 for one edge → state RUN, all registers 0.
- With `WB_BYPASS_EN`: write reg5=0xAA while `d_srcA`=5 → `d_rvalA`=0xAA in the same cycle. Without the macro → old value (0).
